// File: rtl/mips_multicycle.sv
`timescale 1ns/1ps
// Multicycle MIPS core with one shared instruction/data memory port.
// The port uses a req/ready handshake, so memory latency can vary. Outputs
// mem_req/mem_we/mem_addr/mem_wdata/trap are registered from the next state.
// instr_done is decoded combinationally because a store retires on the same
// cycle its write completes.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned EXT_OPS  = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        instr_done,
  output logic        trap
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REGS   = 32;
  localparam bit          EXT_EN = (EXT_OPS != 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEXEC,
    S_RTWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] ir, a, b, aluout, mdr;
  logic [XLEN-1:0] ir_d, a_d, b_d, aluout_d, mdr_d, pc_d;
  logic            req_d, we_d, trap_d;
  logic [XLEN-1:0] addr_d, wdata_d;

  logic [XLEN-1:0] rf [REGS];
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] imm_se, imm_ze, rs_val, rt_val, pc_plus4;
  logic            funct_ok, mem_done, br_taken;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_se   = {{16{ir[15]}}, ir[15:0]};
  assign imm_ze   = {16'd0, ir[15:0]};
  assign rs_val   = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : rf[rt];
  assign pc_plus4 = pc + XLEN'(4);
  assign mem_done = mem_req & mem_ready;
  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);
  assign br_taken = (op == OP_BNE) ? (a != b) : (a == b);

  // Next-state, datapath updates and next values of the registered outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    ir_d       = ir;
    a_d        = a;
    b_d        = b;
    aluout_d   = aluout;
    mdr_d      = mdr;
    rf_we      = 1'b0;
    rf_waddr   = rt;
    rf_wdata   = aluout;
    req_d      = 1'b0;
    we_d       = 1'b0;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    trap_d     = trap;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (mem_done) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        aluout_d = pc_plus4 + {imm_se[29:0], 2'b00};
        case (op)
          OP_RTYPE:              state_d = funct_ok ? S_RTEXEC : S_ERROR;
          OP_LW, OP_SW:          state_d = S_MEMADR;
          OP_ADDI:               state_d = S_IEXEC;
          OP_ANDI, OP_ORI,
          OP_SLTI:               state_d = EXT_EN ? S_IEXEC : S_ERROR;
          OP_BEQ:                state_d = S_BRANCH;
          OP_BNE:                state_d = EXT_EN ? S_BRANCH : S_ERROR;
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        aluout_d = a + imm_se;
        state_d  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_done) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_waddr   = rt;
        rf_wdata   = mdr;
        instr_done = 1'b1;
        pc_d       = pc_plus4;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_done) begin
          instr_done = 1'b1;
          pc_d       = pc_plus4;
          state_d    = S_FETCH;
        end
      end
      S_RTEXEC: begin
        case (funct)
          FN_ADD:  aluout_d = a + b;
          FN_SUB:  aluout_d = a - b;
          FN_AND:  aluout_d = a & b;
          FN_OR:   aluout_d = a | b;
          FN_SLT:  aluout_d = {31'd0, ($signed(a) < $signed(b))};
          default: aluout_d = aluout;
        endcase
        state_d = S_RTWB;
      end
      S_RTWB: begin
        rf_we      = 1'b1;
        rf_waddr   = rd;
        rf_wdata   = aluout;
        instr_done = 1'b1;
        pc_d       = pc_plus4;
        state_d    = S_FETCH;
      end
      S_IEXEC: begin
        case (op)
          OP_ADDI: aluout_d = a + imm_se;
          OP_SLTI: aluout_d = {31'd0, ($signed(a) < $signed(imm_se))};
          OP_ANDI: aluout_d = a & imm_ze;
          OP_ORI:  aluout_d = a | imm_ze;
          default: aluout_d = aluout;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        rf_we      = 1'b1;
        rf_waddr   = rt;
        rf_wdata   = aluout;
        instr_done = 1'b1;
        pc_d       = pc_plus4;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        instr_done = 1'b1;
        pc_d       = br_taken ? aluout : pc_plus4;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        instr_done = 1'b1;
        pc_d       = {pc_plus4[31:28], ir[25:0], 2'b00};
        state_d    = S_FETCH;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    // Memory request for the state being entered; held while it waits
    case (state_d)
      S_FETCH: begin
        req_d  = 1'b1;
        addr_d = pc_d;
      end
      S_MEMRD: begin
        req_d  = 1'b1;
        addr_d = aluout_d;
      end
      S_MEMWR: begin
        req_d   = 1'b1;
        we_d    = 1'b1;
        addr_d  = aluout_d;
        wdata_d = b_d;
      end
      S_ERROR: trap_d = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      aluout    <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= RESET_PC;
      mem_wdata <= '0;
      trap      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc        <= pc_d;
      ir        <= ir_d;
      a         <= a_d;
      b         <= b_d;
      aluout    <= aluout_d;
      mdr       <= mdr_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      trap      <= trap_d;
    end
  end

  // Register file write port; contents survive reset, $0 is never written
  always_ff @(posedge clk) begin
    if (reset && rf_we && (rf_waddr != 5'd0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

endmodule
